pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and instruction-fetch sequencer for the RV32I multi-cycle core.
//  - Fetches the instruction at PC from instruction memory with a req/valid handshake.
//  - Holds the instruction for the execute stage.
//  - After execute completes, uses the ALU flags (less, zero) and result to select the next PC.
//  - Sits upstream of decode/ALU and consumes the ALU's branch outputs.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  TRAP_VECTOR  32'h0000_0100  redirect target on misaligned jump; used only with MISALIGN_TRAP_EN
// PORTS
//  clk          in   1   core clock; all state changes on rising edge
//  rst          in   1   synchronous active-high reset
//  imem_req     out  1   fetch request, address on imem_addr
//  imem_addr    out  32  fetch address (== pc)
//  imem_valid   in   1   instruction returned this cycle
//  imem_rdata   in   32  returned instruction word
//  instr        out  32  latched instruction for decode
//  instr_valid  out  1   instr is held for execute
//  ex_done      in   1   execute/writeback of current instr complete; advance PC
//  branch       in   3   000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu
//  imm          in   32  sign-extended branch/jal offset
//  alu_less     in   1   ALU less flag; signed/unsigned set by decode via aluctr
//  alu_zero     in   1   ALU zero flag
//  alu_result   in   32  ALU sum rs1+imm (jalr target)
//  pc           out  32  current PC
//  pc_plus4     out  32  pc + 4; link value for jal/jalr
//  trap         out  1   1-cycle misaligned-target pulse; tied 0 without MISALIGN_TRAP_EN
// BEHAVIOUR
//  Reset
//  - rst=1: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, trap=0.
//  States
//  - IDLE -> FETCH unconditionally, next cycle.
//  - FETCH: imem_req=1, imem_addr=pc. On imem_valid: instr<=imem_rdata, go EXEC.
//  - EXEC: instr_valid=1, instr stable. On ex_done: pc<=next_pc, go FETCH.
//  Latency
//  - Minimum 2 cycles per instruction: imem_valid in the first FETCH cycle, then ex_done in the first EXEC cycle.
//  Next PC (combinational, sampled at ex_done)
//  - none / 011: pc+4.
//  - jal: pc+imm.
//  - jalr: {alu_result[31:1],1'b0}.
//  - beq: zero ? pc+imm : pc+4.
//  - bne: !zero ? pc+imm : pc+4.
//  - blt: less ? pc+imm : pc+4.
//  - bge: !less ? pc+imm : pc+4.
//  Arithmetic
//  - All adds modulo 2^32: pc=32'hFFFF_FFFC gives pc+4=0; no carry-out is kept.
//  Ignored or undefined inputs
//  - ex_done outside EXEC is ignored.
//  - imem_valid outside FETCH is ignored.
//  - If both arrive together in FETCH, only imem_valid acts.
//  - branch, imm and ALU inputs matter only in the ex_done cycle.
//  - imem_rdata is don't-care when imem_valid=0.
//  Reset priority
//  - rst has priority over every event, including mid-FETCH and mid-EXEC.
//  - An outstanding fetch is abandoned; the imem side shares rst and drops its response.
//  Registered outputs
//  - instr holds its value through FETCH; only instr_valid qualifies it.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined
//  - If next_pc[1:0]!=0 at ex_done: pc<=TRAP_VECTOR, trap=1 for that one cycle, go FETCH.
//  MISALIGN_TRAP_EN undefined
//  - next_pc is loaded as computed, with no check; trap is tied to 0.
// STRUCTURE
//  cpu_pkg holds the shared constants:
//  - branch encodings BR_NONE, BR_JAL, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE;
//  - state encodings ST_IDLE, ST_FETCH, ST_EXEC;
//  - RESET_PC / TRAP_VECTOR defaults.
//  Sub-module branch_cond
//  - Combinational: (branch, alu_less, alu_zero) -> taken, jump_reg.
//  - Reused by the single-cycle core.
// TESTING
//  1. rst 3 cycles, release; imem_valid on 2nd FETCH cycle with 32'h00000013
//     -> imem_addr=0, instr=32'h13, instr_valid in EXEC.
//  2. EXEC at pc=0x40, branch=100, imm=-8, zero=1, ex_done
//     -> next imem_addr=0x38; with zero=0 -> 0x44.
//  3. branch=010, alu_result=32'h0000_1235 -> pc=0x1234;
//     branch=001, pc=0x10, imm=0x7F0 -> pc=0x800.
//  4. pc=32'hFFFF_FFFC, branch=000, ex_done -> pc=0, pc_plus4 read 0 beforehand.
//  5. rst asserted mid-FETCH and again mid-EXEC -> pc=RESET_PC, instr_valid=0, IDLE then FETCH;
//     ex_done during FETCH -> no PC change.
//  6. MISALIGN_TRAP_EN: jal pc=0, imm=6 -> trap 1 cycle, pc=0x100;
//     without macro -> pc=0x6, trap=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the RV32I multi-cycle core: branch codes, sequencer states, PC defaults.
package cpu_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JAL  = 3'b001,
        BR_JALR = 3'b010,
        BR_RSVD = 3'b011,
        BR_BEQ  = 3'b100,
        BR_BNE  = 3'b101,
        BR_BLT  = 3'b110,
        BR_BGE  = 3'b111
    } branch_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

    // jalr clears bit 0 of rs1+imm.
    function automatic logic [31:0] jalr_target(input logic [31:0] sum);
        return sum & ~32'h0000_0001;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch decision: maps branch code and ALU flags to taken / register-indirect jump.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] branch,
    input  logic       alu_less,
    input  logic       alu_zero,
    output logic       taken,
    output logic       jump_reg
);

    always_comb begin
        taken    = 1'b0;
        jump_reg = 1'b0;
        case (branch)
            BR_JAL:  taken = 1'b1;
            BR_JALR: jump_reg = 1'b1;
            BR_BEQ:  taken = alu_zero;
            BR_BNE:  taken = ~alu_zero;
            BR_BLT:  taken = alu_less;
            BR_BGE:  taken = ~alu_less;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch sequencer (IDLE -> FETCH -> EXEC).
// Optional misaligned-target trap enabled by defining MISALIGN_TRAP_EN.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef MISALIGN_TRAP_EN
    , parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        ex_done,
    input  logic [2:0]  branch,
    input  logic [31:0] imm,
    input  logic        alu_less,
    input  logic        alu_zero,
    input  logic [31:0] alu_result,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        taken;
    logic        jump_reg;
    logic [31:0] pc_seq;
    logic [31:0] pc_rel;
    logic [31:0] next_pc;

    branch_cond u_branch_cond (
        .branch   (branch),
        .alu_less (alu_less),
        .alu_zero (alu_zero),
        .taken    (taken),
        .jump_reg (jump_reg)
    );

    assign pc_seq  = pc_q + 32'd4;
    assign pc_rel  = pc_q + imm;
    assign next_pc = jump_reg ? jalr_target(alu_result) : (taken ? pc_rel : pc_seq);

`ifdef MISALIGN_TRAP_EN
    logic trap_q, trap_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef MISALIGN_TRAP_EN
        trap_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                // A late ex_done here is deliberately ignored.
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ex_done) begin
                    state_d = ST_FETCH;
                    pc_d    = next_pc;
`ifdef MISALIGN_TRAP_EN
                    if (next_pc[1:0] != 2'b00) begin
                        pc_d   = TRAP_VECTOR;
                        trap_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef MISALIGN_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign pc          = pc_q;
    assign pc_plus4    = pc_seq;
`ifdef MISALIGN_TRAP_EN
    assign trap        = trap_q;
`else
    assign trap        = 1'b0;
`endif

endmodule
